md_issue_ctrl: RTL and testbench

- Initiator side of the multiply/divide Start/Busy handshake.
- Sits in the E stage beside the md unit. Decides when a mult/multu/div/divu/madd is launched (Start, opsrc) and when mthi/mtlo is written (wsrc).
- Tracks the in-flight operation with a shadow countdown and produces pipeline stalls for D-stage HI/LO users.
- Flags a protocol error if the md unit's Busy outlives the expected latency.

---
 rtl/md_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// E-stage initiator for the multiply/divide Start/Busy handshake.
// Optional madd launch is compiled in with MD_MADD_EN.
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int SLACK       = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        e_valid,
  input  logic [2:0]  e_md_op,
  input  logic        e_flush,
  input  logic        d_md_use,
  input  logic        Busy,
  output logic        Start,
  output logic [2:0]  opsrc,
  output logic [1:0]  wsrc,
  output logic        stall_D,
  output logic        stall_E,
  output logic        md_pending,
  output logic        md_err,
  output logic [15:0] stall_cnt
);

  localparam logic [2:0] alu_mult  = 3'd1;
  localparam logic [2:0] alu_multu = 3'd2;
  localparam logic [2:0] alu_div   = 3'd3;
  localparam logic [2:0] alu_divu  = 3'd4;
  localparam logic [2:0] alu_madd  = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    OVERRUN = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] ovr;

  logic       launch;
  logic       md_use;
  logic [2:0] code;
  logic [7:0] lat;
  logic       idle;
  logic       live;
  logic       issue;

  always_comb begin
    launch = 1'b0;
    md_use = 1'b1;
    code   = 3'd0;
    lat    = 8'(MULT_CYCLES);
    case (e_md_op)
      3'd1: begin launch = 1'b1; code = alu_mult;  end
      3'd2: begin launch = 1'b1; code = alu_multu; end
      3'd3: begin
        launch = 1'b1;
        code   = alu_div;
        lat    = 8'(DIV_CYCLES);
      end
      3'd4: begin
        launch = 1'b1;
        code   = alu_divu;
        lat    = 8'(DIV_CYCLES);
      end
`ifdef MD_MADD_EN
      3'd5: begin launch = 1'b1; code = alu_madd; end
`else
      3'd5: md_use = 1'b0;
`endif
      3'd0: md_use = 1'b0;
      default: ;
    endcase
  end

  assign idle  = (state == IDLE);
  assign live  = e_valid & ~e_flush;
  assign issue = live & launch & idle & ~Busy;

  assign Start = issue;
  assign opsrc = issue ? code : 3'd0;

  always_comb begin
    wsrc = 2'd0;
    if (live && idle && !Busy) begin
      if (e_md_op == 3'd6) wsrc = 2'd1;
      if (e_md_op == 3'd7) wsrc = 2'd2;
    end
  end

  assign stall_E = live & md_use & (~idle | Busy);
  assign stall_D = d_md_use & (Start | ~idle | Busy | stall_E);
  assign md_pending = ~idle;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      ovr       <= 8'd0;
      md_err    <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      if (stall_D && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (issue) begin
            state <= WAIT;
            cnt   <= lat;
          end else if (Busy) begin
            state <= OVERRUN;
            ovr   <= 8'd0;
          end
        end
        WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt <= 8'd1) begin
            state <= Busy ? OVERRUN : IDLE;
            ovr   <= 8'd0;
          end
        end
        OVERRUN: begin
          // ovr saturates at SLACK; md_err stays set until Reset
          if (Busy) begin
            if (ovr < 8'(SLACK)) ovr <= ovr + 8'd1;
            if (ovr + 8'd1 >= 8'(SLACK)) md_err <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed handshake scenarios then random
// traffic against a cycle-count reference model with a modelled md unit.
module tb_md_issue_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;
  localparam int SL = 4;
`ifdef MD_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        e_valid;
  logic [2:0]  e_md_op;
  logic        e_flush;
  logic        d_md_use;
  logic        Busy;
  logic        Start;
  logic [2:0]  opsrc;
  logic [1:0]  wsrc;
  logic        stall_D;
  logic        stall_E;
  logic        md_pending;
  logic        md_err;
  logic [15:0] stall_cnt;

  md_issue_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .SLACK(SL)) dut (
    .Clk(Clk), .Reset(Reset), .e_valid(e_valid), .e_md_op(e_md_op),
    .e_flush(e_flush), .d_md_use(d_md_use), .Busy(Busy), .Start(Start),
    .opsrc(opsrc), .wsrc(wsrc), .stall_D(stall_D), .stall_E(stall_E),
    .md_pending(md_pending), .md_err(md_err), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // stimulus knobs
  bit       v, fl, du, rst, fb;
  bit [2:0] op;
  int       busy_extra = 0;

  // reference model: cycles left in the countdown, overrun bookkeeping
  int trk_left = 0;
  bit in_ovr = 0;
  int ovr_n = 0;
  bit m_err = 0;
  int m_sc = 0;
  int busy_rem = 0;

  logic       o_start, o_se, o_sd;
  logic [1:0] o_ws;
  logic [2:0] o_opsrc;

  function automatic bit launches(input bit [2:0] o);
    return (o >= 3'd1 && o <= 3'd4) || (o == 3'd5 && MADD);
  endfunction

  function automatic bit counts(input bit [2:0] o);
    return (o != 3'd0) && !(o == 3'd5 && !MADD);
  endfunction

  function automatic int lat_of(input bit [2:0] o);
    return (o == 3'd3 || o == 3'd4) ? DC : MC;
  endfunction

  function automatic logic [2:0] code_of(input bit [2:0] o);
    case (o)
      3'd1: return 3'd1;
      3'd2: return 3'd2;
      3'd3: return 3'd3;
      3'd4: return 3'd4;
      3'd5: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input bit vv, input bit [2:0] oo,
                       input bit ff, input bit dd);
    v = vv; op = oo; fl = ff; du = dd;
  endtask

  task automatic step();
    bit b, idle, live, iss, se, sd;
    logic [1:0] ws;
    logic [2:0] oc;
    b = (busy_rem > 0) || fb;
    Busy = b; Reset = rst;
    e_valid = v; e_md_op = op; e_flush = fl; d_md_use = du;
    #4;
    idle = (trk_left == 0) && !in_ovr;
    live = v && !fl;
    iss = live && launches(op) && idle && !b;
    oc = iss ? code_of(op) : 3'd0;
    ws = 2'd0;
    if (live && idle && !b) begin
      if (op == 3'd6) ws = 2'd1;
      if (op == 3'd7) ws = 2'd2;
    end
    se = live && counts(op) && (!idle || b);
    sd = du && (iss || !idle || b || se);
    o_start = Start; o_opsrc = opsrc; o_ws = wsrc;
    o_se = stall_E; o_sd = stall_D;
    chk("start", 16'(Start), 16'(iss));
    chk("opsrc", 16'(opsrc), 16'(oc));
    chk("wsrc", 16'(wsrc), 16'(ws));
    chk("stall_E", 16'(stall_E), 16'(se));
    chk("stall_D", 16'(stall_D), 16'(sd));
    chk("pending", 16'(md_pending), 16'(!idle));
    chk("md_err", 16'(md_err), 16'(m_err));
    chk("stall_cnt", stall_cnt, 16'(m_sc));
    @(posedge Clk);
    #1;
    if (rst) begin
      trk_left = 0; in_ovr = 0; ovr_n = 0;
      m_err = 0; m_sc = 0; busy_rem = 0;
    end else begin
      if (sd && m_sc < 65535) m_sc++;
      if (busy_rem > 0) busy_rem--;
      if (in_ovr) begin
        if (b) begin
          ovr_n++;
          if (ovr_n >= SL) m_err = 1;
        end else in_ovr = 0;
      end else if (trk_left > 0) begin
        trk_left--;
        if (trk_left == 0 && b) begin in_ovr = 1; ovr_n = 0; end
      end else if (iss) begin
        trk_left = lat_of(op);
        busy_rem = lat_of(op) - 1 + busy_extra;
      end else if (b) begin
        in_ovr = 1; ovr_n = 0;
      end
    end
    cyc++;
  endtask

  initial begin
    rst = 0; fb = 0;
    drive(0, 3'd0, 0, 0);
    Reset = 1'b1; Busy = 1'b0; e_valid = 1'b0; e_md_op = 3'd0;
    e_flush = 1'b0; d_md_use = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst_pending", 16'(md_pending), 16'd0);
    chk("rst_cnt", stall_cnt, 16'd0);
    chk("rst_err", 16'(md_err), 16'd0);
    drive(0, 3'd0, 0, 1);
    step();
    chk("idle_sd", 16'(o_sd), 16'd0);

    // mult: pending cycles 1..5, six stalled cycles
    drive(1, 3'd1, 0, 1);
    step();
    chk("mult_start", 16'(o_start), 16'd1);
    chk("mult_opsrc", 16'(o_opsrc), 16'd1);
    drive(0, 3'd0, 0, 1);
    for (int c = 1; c <= 6; c++) begin
      chk("mult_pend", 16'(md_pending), 16'(c <= 5));
      if (c == 6) chk("mult_scnt", stall_cnt, 16'd6);
      step();
    end
    chk("mult_sd_off", 16'(o_sd), 16'd0);

    // div, then a second div held in E until the first retires
    drive(1, 3'd3, 0, 0);
    step();
    drive(0, 3'd0, 0, 0);
    step(); step();
    drive(1, 3'd3, 0, 0);
    for (int c = 3; c <= 11; c++) begin
      step();
      if (c <= 10) chk("div2_stallE", 16'(o_se), 16'd1);
      else chk("div2_start", 16'(o_start), 16'd1);
    end
    drive(0, 3'd0, 0, 0);
    repeat (12) step();

    // mtlo idle, mthi behind a mult
    drive(1, 3'd7, 0, 0);
    step();
    chk("mtlo_wsrc", 16'(o_ws), 16'd2);
    chk("mtlo_start", 16'(o_start), 16'd0);
    drive(1, 3'd1, 0, 0);
    step();
    drive(1, 3'd6, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 5) begin
        chk("mthi_hold_ws", 16'(o_ws), 16'd0);
        chk("mthi_hold_se", 16'(o_se), 16'd1);
      end else chk("mthi_wsrc", 16'(o_ws), 16'd1);
    end
    drive(0, 3'd0, 0, 0);
    step();

    // overrun: Busy high for cycles 1..16 of a div
    busy_extra = 7;
    drive(1, 3'd3, 0, 0);
    step();
    busy_extra = 0;
    drive(0, 3'd0, 0, 0);
    for (int c = 1; c <= 18; c++) begin
      if (c == 14) chk("ovr_err_early", 16'(md_err), 16'd0);
      if (c == 15) chk("ovr_err_set", 16'(md_err), 16'd1);
      if (c == 17) chk("ovr_pend", 16'(md_pending), 16'd1);
      if (c == 18) begin
        chk("ovr_idle", 16'(md_pending), 16'd0);
        chk("ovr_sticky", 16'(md_err), 16'd1);
      end
      if (c < 18) step();
    end

    // flushed multu never launches
    drive(1, 3'd2, 1, 1);
    step();
    chk("flush_start", 16'(o_start), 16'd0);
    chk("flush_pend", 16'(md_pending), 16'd0);

    // reset while the div countdown sits at 3
    drive(1, 3'd3, 0, 1);
    step();
    drive(0, 3'd0, 0, 1);
    repeat (7) step();
    rst = 1;
    step();
    rst = 0;
    chk("rstw_pend", 16'(md_pending), 16'd0);
    chk("rstw_cnt", stall_cnt, 16'd0);
    chk("rstw_err", 16'(md_err), 16'd0);

    // madd
    drive(1, 3'd5, 0, 0);
    step();
    drive(0, 3'd0, 0, 0);
    if (MADD) begin
      chk("madd_start", 16'(o_start), 16'd1);
      chk("madd_opsrc", 16'(o_opsrc), 16'd5);
      repeat (4) step();
      chk("madd_pend5", 16'(md_pending), 16'd1);
      step();
      chk("madd_pend6", 16'(md_pending), 16'd0);
    end else begin
      chk("madd_off_start", 16'(o_start), 16'd0);
      chk("madd_off_se", 16'(o_se), 16'd0);
    end
    repeat (6) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 199) == 0);
      fb = ($urandom_range(0, 39) == 0);
      busy_extra = ($urandom_range(0, 5) == 0) ?
                   int'($urandom_range(0, 7)) : 0;
      step();
    end
    rst = 0; fb = 0; busy_extra = 0;

    // stall counter saturation under a stuck Busy
    rst = 1;
    drive(0, 3'd0, 0, 1);
    step();
    rst = 0; fb = 1;
    for (int i = 0; i < 65540; i++) step();
    chk("sat_cnt", stall_cnt, 16'hFFFF);
    fb = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
